// File: rtl/seg_pipe_adder.sv
// Segmented pipelined adder/subtractor: one SEG-bit slice of the sum is resolved per
// stage, with the inter-slice carry registered and the whole pipe under one global stall.
module seg_pipe_adder #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8,
    parameter int SEG     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sub,
    input  logic [WIDTH_A-1:0] in_a,
    input  logic [WIDTH_B-1:0] in_b,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_A:0]   out_sum
);

    localparam int STAGES = WIDTH_A / SEG;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0]  valid_r;
    logic [STAGES-1:0]  carry_r;
    logic [STAGES-1:0]  sub_r;
    logic [WIDTH_A-1:0] a_r   [STAGES];
    logic [WIDTH_A-1:0] b_r   [STAGES];
    logic [WIDTH_A-1:0] sum_r [STAGES];

    logic               advance_s;
    logic [WIDTH_A-1:0] bext_s;
    logic [STAGES-1:0]  src_v_s;
    logic [STAGES-1:0]  src_c_s;
    logic [STAGES-1:0]  src_sub_s;
    logic [WIDTH_A-1:0] src_a_s   [STAGES];
    logic [WIDTH_A-1:0] src_b_s   [STAGES];
    logic [WIDTH_A-1:0] src_sum_s [STAGES];
    logic [SEG:0]       seg_s     [STAGES];
    logic [WIDTH_A-1:0] nxt_sum_s [STAGES];
    logic [STAGES-1:0]  nxt_c_s;

    assign advance_s = out_ready | ~valid_r[LAST];
    assign in_ready  = advance_s;
    assign out_valid = valid_r[LAST];
    assign out_sum   = {carry_r[LAST], sum_r[LAST]};

    // Stage inputs: stage 0 takes the operands (b pre-inverted for subtract), later stages their predecessor
    always_comb begin
        bext_s       = WIDTH_A'(in_b);
        src_v_s[0]   = in_valid;
        src_a_s[0]   = in_a;
        src_b_s[0]   = in_sub ? ~bext_s : bext_s;
        src_sum_s[0] = {WIDTH_A{1'b0}};
        src_c_s[0]   = in_sub;
        src_sub_s[0] = in_sub;
        for (int k = 1; k < STAGES; k++) begin
            src_v_s[k]   = valid_r[k-1];
            src_a_s[k]   = a_r[k-1];
            src_b_s[k]   = b_r[k-1];
            src_sum_s[k] = sum_r[k-1];
            src_c_s[k]   = carry_r[k-1];
            src_sub_s[k] = sub_r[k-1];
        end
    end

    // Per-stage slice add; the last stage turns its carry into a borrow flag when subtracting
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_s[k] = {1'b0, src_a_s[k][k*SEG +: SEG]}
                     + {1'b0, src_b_s[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, src_c_s[k]};
            nxt_sum_s[k] = src_sum_s[k];
            nxt_sum_s[k][k*SEG +: SEG] = seg_s[k][SEG-1:0];
            if (k == LAST) begin
                nxt_c_s[k] = seg_s[k][SEG] ^ src_sub_s[k];
            end else begin
                nxt_c_s[k] = seg_s[k][SEG];
            end
        end
    end

    // Pipeline registers: flush beats advance, and the whole pipe holds on a stall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            sub_r   <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= {WIDTH_A{1'b0}};
                b_r[k]   <= {WIDTH_A{1'b0}};
                sum_r[k] <= {WIDTH_A{1'b0}};
            end
        end else if (flush) begin
            valid_r <= {STAGES{1'b0}};
        end else if (advance_s) begin
            valid_r <= src_v_s;
            carry_r <= nxt_c_s;
            sub_r   <= src_sub_s;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= src_a_s[k];
                b_r[k]   <= src_b_s[k];
                sum_r[k] <= nxt_sum_s[k];
            end
        end
    end

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder: directed corner cases plus randomized traffic
// against a slot-level reference model whose results come from plain integer arithmetic.
module tb_seg_pipe_adder;

    localparam int WA = 16;
    localparam int WB = 8;
    localparam int SG = 8;
    localparam int ST = WA / SG;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_sub;
    logic [WA-1:0] in_a;
    logic [WB-1:0] in_b;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [WA:0]   out_sum;

    int checks = 0;
    int errors = 0;

    logic        mv   [ST];
    logic [WA:0] mval [ST];

    seg_pipe_adder #(.WIDTH_A(WA), .WIDTH_B(WB), .SEG(SG)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WA:0] ref_res(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                            input logic s);
        logic [WA:0] x;
        logic [WA:0] y;
        x = a;
        y = b;
        return s ? (x - y) : (x + y);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < ST; k++) begin
            mv[k]   = 1'b0;
            mval[k] = '0;
        end
    endtask

    // Compare outputs against the model, then let one clock edge happen and update the model
    task automatic tick();
        logic exp_rdy;
        #1;
        exp_rdy = out_ready | ~mv[ST-1];
        chk("out_valid", out_valid, mv[ST-1]);
        chk("in_ready", in_ready, exp_rdy);
        if (mv[ST-1]) chk("out_sum", out_sum, mval[ST-1]);
        @(posedge clock);
        if (!reset || flush) begin
            model_clear();
        end else if (exp_rdy) begin
            for (int k = ST - 1; k > 0; k--) begin
                mv[k]   = mv[k-1];
                mval[k] = mval[k-1];
            end
            mv[0]   = in_valid;
            mval[0] = ref_res(in_a, in_b, in_sub);
        end
        @(negedge clock);
    endtask

    task automatic set_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic s);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
    endtask

    task automatic direct_op(input string tag, input logic [WA-1:0] a, input logic [WB-1:0] b,
                             input logic s, input logic [WA:0] exp);
        out_ready = 1'b1;
        flush     = 1'b0;
        set_op(a, b, s);
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_lat"}, out_valid, 1'b1);
        chk(tag, out_sum, exp);
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_a      = '0;
        in_b      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #12;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_sum", out_sum, 17'h0);
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();

        direct_op("add_carry", 16'h00FF, 8'h01, 1'b0, 17'h00100);
        direct_op("add_max",   16'hFFFF, 8'hFF, 1'b0, 17'h100FE);
        direct_op("sub_borrow_seg", 16'h0100, 8'h01, 1'b1, 17'h000FF);
        direct_op("sub_neg",   16'h0005, 8'h07, 1'b1, 17'h1FFFE);
        direct_op("sub_mid",   16'h1234, 8'h34, 1'b1, 17'h01200);

        // back-to-back mixed add/sub
        set_op(16'h1111, 8'h22, 1'b0); tick();
        set_op(16'h0033, 8'h44, 1'b1); tick();
        set_op(16'hFF80, 8'h90, 1'b0); tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // back-pressure: four stalled cycles with new input offered
        set_op(16'hABCD, 8'hEF, 1'b0); tick();
        set_op(16'h0001, 8'h02, 1'b1); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(16'($urandom), 8'($urandom), 1'($urandom));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        // flush with operations in flight and a same-edge input
        set_op(16'h4000, 8'h11, 1'b0); tick();
        set_op(16'h5000, 8'h22, 1'b1); tick();
        flush = 1'b1;
        set_op(16'h6000, 8'h33, 1'b0); tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        direct_op("post_flush", 16'h7FFF, 8'h01, 1'b0, 17'h08000);

        // asynchronous reset mid-cycle with two operations in flight
        set_op(16'h2222, 8'h11, 1'b0); tick();
        set_op(16'h3333, 8'h22, 1'b1); tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_sum", out_sum, 17'h0);
        model_clear();
        @(negedge clock);
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();

        // randomized traffic with occasional stalls and flushes
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_sub    = 1'($urandom);
            in_a      = 16'($urandom);
            in_b      = 8'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
